// File: rtl/snes_multi_poller.sv
// -----------------------------------------------------------------------------
// snes_multi_poller
//   Polls NUM_PADS SNES/NES style serial pads over one shared latch/clock pair
//   at a fixed rate. It returns registered active-high button vectors, a
//   one-cycle "newly pressed" pulse per button and a one-cycle update strobe.
//
//   Optional feature macro: PAD_DETECT_EN
//     defined   : a pad whose line reads all zeros for a whole frame is treated
//                 as absent. Its pad_present bit clears and its buttons and
//                 pressed slices load as zero.
//     undefined : pad_present reads all ones after the first completed frame,
//                 and raw data loads unfiltered.
//
// Ports
//   clk_50            in   system clock
//   reset             in   asynchronous, active-high
//   enable            in   1 = new frames may start
//   controller_dout   in   per-pad serial data, active-low, asynchronous
//   controller_latch  out  shared latch, active-high
//   controller_clk    out  shared clock, idles high
//   buttons           out  pad p bit i at [p*NUM_BITS+i], 1 = pressed
//   pressed           out  one-cycle pulse per newly pressed button
//   updated           out  one-cycle pulse when buttons/pressed load
//   pad_present       out  per-pad presence flag
//   dbg_state_o       out  current FSM state (IDLE=0 LATCH=1 HIGH=2 LOW=3 DONE=4)
// -----------------------------------------------------------------------------
module snes_multi_poller #(
   parameter int NUM_PADS    = 2,
   parameter int NUM_BITS    = 16,
   parameter int CLK_DIV     = 300,
   parameter int POLL_PERIOD = 833333
) (
   input  logic                         clk_50,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [NUM_PADS-1:0]          controller_dout,
   output logic                         controller_latch,
   output logic                         controller_clk,
   output logic [NUM_PADS*NUM_BITS-1:0] buttons,
   output logic [NUM_PADS*NUM_BITS-1:0] pressed,
   output logic                         updated,
   output logic [NUM_PADS-1:0]          pad_present,
   output logic [2:0]                   dbg_state_o
);

   localparam int TW = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
   localparam int CW = $clog2(2 * CLK_DIV);
   localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
   localparam int VW = NUM_PADS * NUM_BITS;

   localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_PERIOD - 1);
   localparam logic [TW-1:0] TIMER_ONE    = TW'(1);
   localparam logic [CW-1:0] LATCH_LAST   = CW'(2 * CLK_DIV - 1);
   localparam logic [CW-1:0] DIV_LAST     = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);
   localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_BITS - 1);
   localparam logic [IW-1:0] IDX_ONE      = IW'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             latch_q, latch_d;
   logic             sclk_q, sclk_d;
   logic [NUM_PADS-1:0] sync1_q, sync2_q;
   logic [VW-1:0]    shadow_q;
   logic [VW-1:0]    buttons_q, pressed_q;
   logic             updated_q;
   logic [NUM_PADS-1:0] present_q;

   logic             shift_en;
   logic             load_en;
   logic [VW-1:0]    btn_new, prs_new;
   logic [NUM_PADS-1:0] present_new;

   // -------------------------------------------------------------------------
   // Next-state logic. The poll timer runs freely down to zero and is
   // reloaded only when a frame starts, so the latch-to-latch spacing equals
   // POLL_PERIOD whenever the frame fits inside it.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      timer_d  = (timer_q != '0) ? (timer_q - TIMER_ONE) : '0;
      shift_en = 1'b0;
      load_en  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if ((timer_q == '0) && enable) begin
               state_d = S_LATCH;
               cnt_d   = '0;
               timer_d = TIMER_RELOAD;
            end
         end
         S_LATCH: begin
            if (cnt_q == LATCH_LAST) begin
               state_d = S_HIGH;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (cnt_q == DIV_LAST) begin
               // Sample on the last high cycle, when the pad output has
               // had the whole half period to settle through the synchroniser.
               shift_en = 1'b1;
               state_d  = S_LOW;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_LOW: begin
            if (cnt_q == DIV_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IDX_ONE;
                  state_d = S_HIGH;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DONE: begin
            load_en = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pin levels are registered from the next state so they switch
      // glitch-free in step with state_q.
      latch_d = (state_d == S_LATCH);
      sclk_d  = (state_d != S_LOW);
   end

   // -------------------------------------------------------------------------
   // Frame result: shadow data, optionally filtered for absent pads.
   // -------------------------------------------------------------------------
   always_comb begin
      btn_new     = '0;
      present_new = '0;
      for (int p = 0; p < NUM_PADS; p++) begin
`ifdef PAD_DETECT_EN
         // An all-zero line inverts to all ones: treat it as a missing pad.
         if (&shadow_q[p*NUM_BITS +: NUM_BITS]) begin
            btn_new[p*NUM_BITS +: NUM_BITS] = '0;
            present_new[p]                  = 1'b0;
         end else begin
            btn_new[p*NUM_BITS +: NUM_BITS] = shadow_q[p*NUM_BITS +: NUM_BITS];
            present_new[p]                  = 1'b1;
         end
`else
         btn_new[p*NUM_BITS +: NUM_BITS] = shadow_q[p*NUM_BITS +: NUM_BITS];
         present_new[p]                  = 1'b1;
`endif
      end
      prs_new = btn_new & ~buttons_q;
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_50 or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         latch_q   <= 1'b0;
         sclk_q    <= 1'b1;
         sync1_q   <= '1;
         sync2_q   <= '1;
         shadow_q  <= '0;
         buttons_q <= '0;
         pressed_q <= '0;
         updated_q <= 1'b0;
         present_q <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         latch_q   <= latch_d;
         sclk_q    <= sclk_d;
         sync1_q   <= controller_dout;
         sync2_q   <= sync1_q;

         if (shift_en) begin
            for (int p = 0; p < NUM_PADS; p++) begin
               shadow_q[p*NUM_BITS + int'(idx_q)] <= ~sync2_q[p];
            end
         end

         pressed_q <= '0;
         updated_q <= 1'b0;
         if (load_en) begin
            buttons_q <= btn_new;
            pressed_q <= prs_new;
            updated_q <= 1'b1;
            present_q <= present_new;
         end
      end
   end

   assign controller_latch = latch_q;
   assign controller_clk   = sclk_q;
   assign buttons          = buttons_q;
   assign pressed          = pressed_q;
   assign updated          = updated_q;
   assign pad_present      = present_q;
   assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_snes_multi_poller.sv
// -----------------------------------------------------------------------------
// tb_snes_multi_poller
//   Directed bench for snes_multi_poller with two modelled pads, 16 bits,
//   CLK_DIV=4, POLL_PERIOD=400. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_snes_multi_poller;

   localparam int NP = 2;
   localparam int NB = 16;
   localparam int CD = 4;
   localparam int PP = 400;

   // ---------------- clock / reset ----------------
   logic clk_50 = 1'b0;
   logic reset  = 1'b1;
   logic enable = 1'b1;
   always #5 clk_50 = ~clk_50;

   logic [NP-1:0]    controller_dout;
   logic             controller_latch;
   logic             controller_clk;
   logic [NP*NB-1:0] buttons;
   logic [NP*NB-1:0] pressed;
   logic             updated;
   logic [NP-1:0]    pad_present;
   logic [2:0]       dbg_state_o;

   snes_multi_poller #(
      .NUM_PADS    (NP),
      .NUM_BITS    (NB),
      .CLK_DIV     (CD),
      .POLL_PERIOD (PP)
   ) dut (
      .clk_50           (clk_50),
      .reset            (reset),
      .enable           (enable),
      .controller_dout  (controller_dout),
      .controller_latch (controller_latch),
      .controller_clk   (controller_clk),
      .buttons          (buttons),
      .pressed          (pressed),
      .updated          (updated),
      .pad_present      (pad_present),
      .dbg_state_o      (dbg_state_o)
   );

   // ---------------- pad model ----------------
   // Latch parks the shift register on bit 0; each rising clock with the
   // latch low advances one bit. Past the last bit the line reads 1.
   logic [15:0] word0 = 16'hFFFE;
   logic [15:0] word1 = 16'hFFFF;
   logic [1:0]  tie0  = 2'b00;
   int          pidx  = 16;

   always @(posedge controller_latch) pidx = 0;
   always @(posedge controller_clk) if (!controller_latch && pidx < 16) pidx = pidx + 1;

   assign controller_dout[0] = tie0[0] ? 1'b0 : ((pidx < 16) ? word0[pidx[3:0]] : 1'b1);
   assign controller_dout[1] = tie0[1] ? 1'b0 : ((pidx < 16) ? word1[pidx[3:0]] : 1'b1);

   // ---------------- event monitor ----------------
   int cyc      = 0;
   int rise_cnt = 0;
   int upd_cnt  = 0;
   logic latch_prev = 1'b0;

   always @(posedge clk_50) cyc = cyc + 1;

   always @(negedge clk_50) begin
      if (controller_latch && !latch_prev) rise_cnt = rise_cnt + 1;
      latch_prev = controller_latch;
      if (updated === 1'b1) upd_cnt = upd_cnt + 1;
   end

   // ---------------- scoreboard ----------------
   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver / wait tasks ----------------
   task automatic wait_latch_rise(input string tag, input int budget,
                                  output int n_o, output int cyc_o);
      logic prev;
      logic got;
      prev  = controller_latch;
      got   = 1'b0;
      n_o   = 0;
      cyc_o = -1;
      while (!got && n_o < budget) begin
         @(negedge clk_50);
         n_o++;
         if (controller_latch && !prev) begin
            got   = 1'b1;
            cyc_o = cyc;
         end
         prev = controller_latch;
      end
      chk(tag, {63'd0, got}, 64'd1);
   endtask

   task automatic wait_updated(input string tag, input int budget);
      int   n;
      logic got;
      n   = 0;
      got = 1'b0;
      while (!got && n < budget) begin
         @(negedge clk_50);
         n++;
         if (updated === 1'b1) got = 1'b1;
      end
      chk(tag, {63'd0, got}, 64'd1);
   endtask

   task automatic wait_clk_falls(input string tag, input int falls_req, input int budget);
      int   n;
      int   falls;
      logic pc;
      n     = 0;
      falls = 0;
      pc    = controller_clk;
      while (falls < falls_req && n < budget) begin
         @(negedge clk_50);
         n++;
         if (pc && !controller_clk) falls++;
         pc = controller_clk;
      end
      chk(tag, 64'(falls), 64'(falls_req));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      int c_rise;
      int c_prev;
      int hi;
      int lo;
      int hi_ok;
      int lo_ok;
      int r0;
      int u0;
      logic [1:0]  exp_present;
      logic [31:0] exp_btn;
      logic [31:0] exp_prs;

      // Reset held with enable high
      reset  = 1'b1;
      enable = 1'b1;
      repeat (3) @(negedge clk_50);
      chk("rst_latch",   {63'd0, controller_latch}, 64'd0);
      chk("rst_clk",     {63'd0, controller_clk},   64'd1);
      chk("rst_buttons", 64'(buttons),              64'd0);
      chk("rst_pressed", 64'(pressed),              64'd0);
      chk("rst_updated", {63'd0, updated},          64'd0);
      chk("rst_present", 64'(pad_present),          64'd0);
      chk("rst_state",   64'(dbg_state_o),          64'd0);

      // Release: frame shape
      reset = 1'b0;
      wait_latch_rise("t1_first_latch", 10, n, c_rise);
      chk("t1_latch_delay_le2", {63'd0, (n <= 2)}, 64'd1);

      hi = 1;
      while (hi < 50) begin
         @(negedge clk_50);
         if (controller_latch) hi++;
         else break;
      end
      chk("t1_latch_high_cycles", 64'(hi), 64'd8);

      hi_ok = 0;
      lo_ok = 0;
      for (int b = 0; b < 16; b++) begin
         hi = 0;
         while (controller_clk && hi < 50) begin
            hi++;
            @(negedge clk_50);
         end
         lo = 0;
         while (!controller_clk && lo < 50) begin
            lo++;
            @(negedge clk_50);
         end
         if (hi == 4) hi_ok++;
         if (lo == 4) lo_ok++;
      end
      chk("t1_clk_high_runs_of_4", 64'(hi_ok), 64'd16);
      chk("t1_clk_low_runs_of_4",  64'(lo_ok), 64'd16);

      // Frame 1 result: pad0 bit0 pressed
      wait_updated("t2_upd1", 50);
      chk("t2_buttons", 64'(buttons),     64'h0000_0001);
      chk("t2_pressed", 64'(pressed),     64'h0000_0001);
      chk("t2_present", 64'(pad_present), 64'h3);
      word0 = 16'hFFF6;
      @(negedge clk_50);
      chk("t2_updated_one_cycle", {63'd0, updated}, 64'd0);
      chk("t2_pressed_one_cycle", 64'(pressed),     64'd0);

      // Frame 2: bits 0 and 3 held low -> bit 3 newly pressed
      c_prev = c_rise;
      wait_latch_rise("t1_second_latch", 500, n, c_rise);
      chk("t1_latch_spacing", 64'(c_rise - c_prev), 64'd400);
      wait_updated("t3_upd2", 300);
      chk("t3_buttons", 64'(buttons), 64'h0000_0009);
      chk("t3_pressed", 64'(pressed), 64'h0000_0008);
      @(negedge clk_50);
      chk("t3_pressed_clears", 64'(pressed),     64'd0);
      chk("t3_updated_clears", {63'd0, updated}, 64'd0);

      // Frame 3: identical data -> no new presses
      wait_updated("t3_upd3", 600);
      chk("t3_buttons_held", 64'(buttons), 64'h0000_0009);
      chk("t3_pressed_held", 64'(pressed), 64'd0);
      @(negedge clk_50);
      #1;
      chk("t3_update_pulse_count", 64'(upd_cnt), 64'd3);

      // Reset during bit 7 low phase
      wait_latch_rise("t4_latch", 600, n, c_rise);
      wait_clk_falls("t4_reach_bit7_low", 8, 300);
      reset = 1'b1;
      #1;
      chk("t4_abort_clk",     {63'd0, controller_clk},   64'd1);
      chk("t4_abort_latch",   {63'd0, controller_latch}, 64'd0);
      chk("t4_abort_buttons", 64'(buttons),              64'd0);
      chk("t4_abort_state",   64'(dbg_state_o),          64'd0);
      repeat (3) @(negedge clk_50);
      reset = 1'b0;
      wait_latch_rise("t4_restart", 10, n, c_rise);
      chk("t4_restart_delay_le2", {63'd0, (n <= 2)}, 64'd1);
      wait_updated("t4_upd", 200);
      chk("t4_buttons", 64'(buttons),     64'h0000_0009);
      chk("t4_pressed", 64'(pressed),     64'h0000_0009);
      chk("t4_present", 64'(pad_present), 64'h3);

      // Pad 1 line tied low
      tie0 = 2'b10;
`ifdef PAD_DETECT_EN
      exp_present = 2'b01;
      exp_btn     = 32'h0000_0009;
      exp_prs     = 32'h0000_0000;
`else
      exp_present = 2'b11;
      exp_btn     = 32'hFFFF_0009;
      exp_prs     = 32'hFFFF_0000;
`endif
      wait_updated("t5_upd_dead", 600);
      chk("t5_present", 64'(pad_present), 64'(exp_present));
      chk("t5_buttons", 64'(buttons),     64'(exp_btn));
      chk("t5_pressed", 64'(pressed),     64'(exp_prs));
      tie0 = 2'b00;
      wait_updated("t5_upd_restored", 600);
      chk("t5_restored_buttons", 64'(buttons),     64'h0000_0009);
      chk("t5_restored_present", 64'(pad_present), 64'h3);
      chk("t5_restored_pressed", 64'(pressed),     64'd0);

      // enable low: no frames at all
      enable = 1'b0;
      word0  = 16'h5A5A;
      word1  = 16'h0FF0;
      @(negedge clk_50);
      #1;
      r0 = rise_cnt;
      u0 = upd_cnt;
      repeat (1000) @(negedge clk_50);
      #1;
      chk("t6_no_latch_while_disabled",   64'(rise_cnt),             64'(r0));
      chk("t6_no_update_while_disabled",  64'(upd_cnt),              64'(u0));
      chk("t6_idle_while_disabled",       64'(dbg_state_o),          64'd0);

      // Re-enable, then drop enable mid-shift: the frame still completes
      enable = 1'b1;
      wait_latch_rise("t6_reenable_latch", 10, n, c_rise);
      wait_clk_falls("t6_mid_shift", 3, 100);
      enable = 1'b0;
      wait_updated("t6_upd_after_drop", 300);
      chk("t6_buttons", 64'(buttons), 64'hF00F_A5A5);
      chk("t6_pressed", 64'(pressed), 64'hF00F_A5A4);
      @(negedge clk_50);
      #1;
      r0 = rise_cnt;
      repeat (600) @(negedge clk_50);
      #1;
      chk("t6_no_latch_after_drop", 64'(rise_cnt), 64'(r0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
